// File: rtl/bsg_link_downstream_sipo_credit_if.sv
// ----------------------------------------------------------------------------
// bsg_link_downstream_sipo_credit_if
//   Bundles the channel-side input, the core-side FIFO head handshake and the
//   credit/error outputs of the downstream link receiver.
//
//   Handshake semantics (one place, applies to every user of this interface):
//     io_valid_i               : one channel beat is transferred on every clock
//                                edge where it is high; there is no ready, the
//                                upstream credit scheme guarantees room.
//     core_valid_o/core_yumi_i : valid/yumi.  core_data_o is stable while
//                                core_valid_o is high and unpopped.  A word is
//                                consumed on the edge where both are high.
//                                yumi without valid is a protocol error.
//     token_o                  : single-cycle credit pulse, one per
//                                TOKEN_DECIMATION consumed words.
//     error_o                  : sticky until reset.
//
//   Modports
//     slave  : the receiver (drives core_valid_o/core_data_o/token_o/error_o)
//     master : the environment (drives io_valid_i/io_data_i/core_yumi_i)
// ----------------------------------------------------------------------------
interface bsg_link_downstream_sipo_credit_if #(
   parameter int CHANNEL_WIDTH = 32,
   parameter int RATIO         = 2
);
   logic                             io_valid_i;
   logic [CHANNEL_WIDTH-1:0]         io_data_i;
   logic                             core_valid_o;
   logic [CHANNEL_WIDTH*RATIO-1:0]   core_data_o;
   logic                             core_yumi_i;
   logic                             token_o;
   logic                             error_o;

   modport slave (
      input  io_valid_i, io_data_i, core_yumi_i,
      output core_valid_o, core_data_o, token_o, error_o
   );

   modport master (
      output io_valid_i, io_data_i, core_yumi_i,
      input  core_valid_o, core_data_o, token_o, error_o
   );
endinterface

// File: rtl/bsg_link_downstream_sipo_credit.sv
// ----------------------------------------------------------------------------
// bsg_link_downstream_sipo_credit
//   Receive side of the serialized link.  Narrow channel beats are gathered
//   into full core words (beat 0 = least significant slice), pushed into a
//   first-word-fall-through FIFO, and handed to the core with valid/yumi.
//   Every TOKEN_DECIMATION consumed words a one-cycle token is returned to
//   the upstream credit counter.  Overflow and underflow set a sticky error.
//
//   Ports
//     clk   : clock, all state updates on posedge
//     rst   : asynchronous active-high reset
//     link  : bsg_link_downstream_sipo_credit_if.slave
//             (io_valid_i, io_data_i, core_valid_o, core_data_o,
//              core_yumi_i, token_o, error_o)
// ----------------------------------------------------------------------------
module bsg_link_downstream_sipo_credit #(
   parameter int CHANNEL_WIDTH    = 32,
   parameter int RATIO            = 2,
   parameter int FIFO_ELS         = 16,
   parameter int TOKEN_DECIMATION = 8
) (
   input  logic                                 clk,
   input  logic                                 rst,
   bsg_link_downstream_sipo_credit_if.slave     link
);

   localparam int CW  = CHANNEL_WIDTH;
   localparam int WW  = CHANNEL_WIDTH * RATIO;
   localparam int AW  = (FIFO_ELS > 1) ? $clog2(FIFO_ELS) : 1;
   localparam int PW  = AW + 1;
   localparam int BW  = (RATIO > 1) ? $clog2(RATIO) : 1;
   localparam int CRW = (TOKEN_DECIMATION > 1) ? $clog2(TOKEN_DECIMATION) : 1;

   // State
   logic [BW-1:0]  beat_cnt_q, beat_cnt_d;
   logic [WW-1:0]  asm_q, asm_d;
   logic [PW-1:0]  wr_ptr_q, wr_ptr_d;
   logic [PW-1:0]  rd_ptr_q, rd_ptr_d;
   logic [CRW-1:0] credit_q, credit_d;
   logic           token_q, token_d;
   logic           error_q, error_d;
   logic [WW-1:0]  mem_q [FIFO_ELS];

   // Decoded events
   logic full, empty, last_beat, push, pop, overflow, underflow;

   always_comb begin
      empty     = (wr_ptr_q == rd_ptr_q);
      full      = (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]) &&
                  (wr_ptr_q[AW] != rd_ptr_q[AW]);
      last_beat = link.io_valid_i && (beat_cnt_q == BW'(RATIO - 1));
      pop       = link.core_yumi_i && !empty;
      underflow = link.core_yumi_i && empty;
      // A same-cycle pop frees the slot being written, so a full FIFO can
      // still accept the word.
      push      = last_beat && (!full || pop);
      overflow  = last_beat && full && !pop;
   end

   // Deserializer: drop the incoming beat into its slice.  asm_d is the
   // completed word on the last beat and is what gets written to the FIFO.
   always_comb begin
      beat_cnt_d = beat_cnt_q;
      asm_d      = asm_q;
      if (link.io_valid_i) begin
         for (int k = 0; k < RATIO; k++) begin
            if (beat_cnt_q == BW'(k)) begin
               asm_d[k*CW +: CW] = link.io_data_i;
            end
         end
         if (last_beat) begin
            beat_cnt_d = '0;
         end else begin
            beat_cnt_d = beat_cnt_q + BW'(1);
         end
      end
   end

   // Pointers, credit and error
   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      credit_d = credit_q;
      token_d  = 1'b0;
      error_d  = error_q | overflow | underflow;
      if (push) begin
         wr_ptr_d = wr_ptr_q + PW'(1);
      end
      if (pop) begin
         rd_ptr_d = rd_ptr_q + PW'(1);
         if (credit_q == CRW'(TOKEN_DECIMATION - 1)) begin
            credit_d = '0;
            token_d  = 1'b1;
         end else begin
            credit_d = credit_q + CRW'(1);
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         beat_cnt_q <= '0;
         asm_q      <= '0;
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         credit_q   <= '0;
         token_q    <= 1'b0;
         error_q    <= 1'b0;
      end else begin
         beat_cnt_q <= beat_cnt_d;
         asm_q      <= asm_d;
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         credit_q   <= credit_d;
         token_q    <= token_d;
         error_q    <= error_d;
      end
   end

   // Storage needs no reset: contents are only observable through the
   // pointers, and core_data_o is forced to zero while empty.
   always_ff @(posedge clk) begin
      if (push) begin
         mem_q[wr_ptr_q[AW-1:0]] <= asm_d;
      end
   end

   assign link.core_valid_o = !empty;
   assign link.core_data_o  = empty ? '0 : mem_q[rd_ptr_q[AW-1:0]];
   assign link.token_o      = token_q;
   assign link.error_o      = error_q;

endmodule

// File: tb/tb_bsg_link_downstream_sipo_credit.sv
module tb_bsg_link_downstream_sipo_credit;

   localparam int CW = 32;
   localparam int RATIO = 2;
   localparam int WW = CW * RATIO;
   localparam int TD = 8;

   // ---------------- clock / reset ----------------
   logic clk = 1'b0;
   logic rst = 1'b0;
   always #5 clk = ~clk;

   bsg_link_downstream_sipo_credit_if #(.CHANNEL_WIDTH(CW), .RATIO(RATIO)) lnk ();

   bsg_link_downstream_sipo_credit #(
      .CHANNEL_WIDTH(CW), .RATIO(RATIO), .FIFO_ELS(16), .TOKEN_DECIMATION(TD)
   ) dut (
      .clk  (clk),
      .rst  (rst),
      .link (lnk)
   );

   // ---------------- scoreboard state ----------------
   logic [WW-1:0] exp_q[$];
   int  n_checks = 0;
   int  n_errors = 0;
   int  pop_cnt = 0;
   int  tok_seen = 0;
   bit  tok_exp_next = 0;
   bit  mon_en = 0;
   bit  auto_yumi = 0;
   bit  manual_yumi = 0;

   task automatic check(input string nm, input logic [WW-1:0] act, input logic [WW-1:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   // ---------------- monitor ----------------
   // Drives yumi on the falling edge, then compares any word that will be
   // consumed at the next rising edge, and checks token timing.
   always @(negedge clk) begin
      lnk.core_yumi_i = auto_yumi ? lnk.core_valid_o : manual_yumi;
      if (mon_en && !rst) begin
         check("token", {63'd0, lnk.token_o}, {63'd0, tok_exp_next});
         if (lnk.token_o) tok_seen++;
         tok_exp_next = 0;
         if (lnk.core_valid_o && lnk.core_yumi_i) begin
            if (exp_q.size() == 0) begin
               n_checks++;
               n_errors++;
               $display("FAIL unexpected_word: got %h expected none", lnk.core_data_o);
            end else begin
               check("word", lnk.core_data_o, exp_q.pop_front());
            end
            pop_cnt++;
            if (pop_cnt % TD == 0) tok_exp_next = 1;
         end
      end
   end

   // ---------------- driver tasks ----------------
   task automatic do_reset();
      @(posedge clk); #1;
      auto_yumi = 0;
      manual_yumi = 0;
      lnk.io_valid_i = 1'b0;
      rst = 1'b1;
      #1;
      check("rst_valid", {63'd0, lnk.core_valid_o}, 64'd0);
      check("rst_data",  lnk.core_data_o, 64'd0);
      check("rst_token", {63'd0, lnk.token_o}, 64'd0);
      check("rst_error", {63'd0, lnk.error_o}, 64'd0);
      exp_q.delete();
      pop_cnt = 0;
      tok_seen = 0;
      tok_exp_next = 0;
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      mon_en = 1;
   endtask

   task automatic beat(input logic [CW-1:0] d);
      lnk.io_valid_i = 1'b1;
      lnk.io_data_i  = d;
      @(posedge clk); #1;
      lnk.io_valid_i = 1'b0;
   endtask

   task automatic send_word(input logic [WW-1:0] w, input bit push_exp, input bit yumi_last);
      beat(w[CW-1:0]);
      if (push_exp) exp_q.push_back(w);
      if (yumi_last) manual_yumi = 1;
      beat(w[WW-1:CW]);
      manual_yumi = 0;
   endtask

   task automatic drain();
      auto_yumi = 1;
      for (int i = 0; i < 200 && exp_q.size() != 0; i++) @(posedge clk);
      repeat (3) @(posedge clk);
      #1 auto_yumi = 0;
      check("drain_left", 64'(exp_q.size()), 64'd0);
      @(negedge clk);
      check("drain_valid", {63'd0, lnk.core_valid_o}, 64'd0);
      @(posedge clk); #1;
   endtask

   function automatic logic [WW-1:0] pat(input int i);
      return {32'hC000_0000 | 32'(i), 32'h3000_0000 | 32'(i)};
   endfunction

   // ---------------- stimulus ----------------
   initial begin
      lnk.io_valid_i = 1'b0;
      lnk.io_data_i  = '0;
      lnk.core_yumi_i = 1'b0;

      // 1) two beats -> one word, visible one cycle after the second beat
      do_reset();
      beat(32'h1111_1111);
      exp_q.push_back(64'h2222_2222_1111_1111);
      beat(32'h2222_2222);
      @(negedge clk);
      check("t1_valid", {63'd0, lnk.core_valid_o}, 64'd1);
      check("t1_data",  lnk.core_data_o, 64'h2222_2222_1111_1111);
      @(posedge clk); #1;

      // 2) gap between beats holds the partial word
      beat(32'hAAAA_0001);
      repeat (5) @(posedge clk);
      #1;
      exp_q.push_back(64'hBBBB_0002_AAAA_0001);
      beat(32'hBBBB_0002);
      @(negedge clk);
      check("t2_head_still_t1", lnk.core_data_o, 64'h2222_2222_1111_1111);
      @(posedge clk); #1;
      drain();
      check("t2_error", {63'd0, lnk.error_o}, 64'd0);

      // 3a) fill, then overflow without pop
      do_reset();
      for (int i = 0; i < 16; i++) send_word(pat(i), 1, 0);
      @(negedge clk);
      check("t3_full_error0", {63'd0, lnk.error_o}, 64'd0);
      @(posedge clk); #1;
      send_word(64'hDEAD_BEEF_0BAD_F00D, 0, 0);
      @(negedge clk);
      check("t3_ovf_error", {63'd0, lnk.error_o}, 64'd1);
      check("t3_ovf_head",  lnk.core_data_o, pat(0));
      @(posedge clk); #1;
      drain();

      // 3b) 17th completion with same-cycle pop is accepted
      do_reset();
      for (int i = 0; i < 16; i++) send_word(pat(i + 32), 1, 0);
      send_word(pat(99), 1, 1);
      @(negedge clk);
      check("t3b_error", {63'd0, lnk.error_o}, 64'd0);
      check("t3b_head",  lnk.core_data_o, pat(33));
      @(posedge clk); #1;
      drain();
      check("t3b_pops", 64'(pop_cnt), 64'd17);

      // 4) streaming 24 words -> 3 tokens
      do_reset();
      auto_yumi = 1;
      for (int i = 0; i < 24; i++) send_word(pat(i + 100), 1, 0);
      drain();
      check("t4_tokens", 64'(tok_seen), 64'd3);
      check("t4_pops",   64'(pop_cnt), 64'd24);

      // 5) yumi while empty
      do_reset();
      manual_yumi = 1;
      repeat (2) @(posedge clk);
      #1 manual_yumi = 0;
      @(negedge clk);
      check("t5_error", {63'd0, lnk.error_o}, 64'd1);
      check("t5_valid", {63'd0, lnk.core_valid_o}, 64'd0);
      @(posedge clk); #1;
      send_word(pat(7), 1, 0);
      drain();
      check("t5_tokens", 64'(tok_seen), 64'd0);

      // 6) reset with partial word, buffered words and credit_cnt=5
      do_reset();
      for (int i = 0; i < 5; i++) send_word(pat(i + 200), 1, 0);
      drain();
      for (int i = 0; i < 3; i++) send_word(pat(i + 210), 1, 0);
      beat(32'hAAAA_AAAA);
      @(negedge clk);
      check("t6_pre_valid", {63'd0, lnk.core_valid_o}, 64'd1);
      check("t6_pre_tokens", 64'(tok_seen), 64'd0);
      do_reset();
      for (int i = 0; i < 8; i++) send_word(pat(i + 300), 1, 0);
      @(negedge clk);
      check("t6_fresh_head", lnk.core_data_o, pat(300));
      @(posedge clk); #1;
      drain();
      check("t6_tokens", 64'(tok_seen), 64'd1);
      check("t6_pops",   64'(pop_cnt), 64'd8);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

   // Global time limit
   initial begin
      #200000;
      $display("FAIL timeout: got no finish expected finish");
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors + 1);
      $finish;
   end

endmodule
